// File: rtl/rr_shared_reg_arbiter_pkg.sv
// Shared definitions for the round-robin shared-register arbiter.
// Contents: FSM state encoding and width helpers for ID / counter fields.
package rr_shared_reg_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Field width for an index/count range of v values; never narrower than 1 bit.
    function automatic int unsigned idw(input int unsigned v);
        return (v <= 2) ? 1 : clog2(v);
    endfunction

endpackage

// File: rtl/rr_shared_reg_arbiter_if.sv
// Requester-side bus of the shared-register arbiter.
// master: producer side (drives req/wdata, observes grant and register state).
// slave : arbiter side (consumes req/wdata, drives gnt/ack/ack_id/q/busy).
interface rr_shared_reg_arbiter_if
    import rr_shared_reg_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
) ();

    localparam int unsigned ID_W = idw(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       gnt;
    logic                   ack;
    logic [ID_W-1:0]        ack_id;
    logic [WIDTH-1:0]       q;
    logic                   busy;

    modport master (
        output req, wdata,
        input  gnt, ack, ack_id, q, busy
    );

    modport slave (
        input  req, wdata,
        output gnt, ack, ack_id, q, busy
    );

endinterface

// File: rtl/rr_shared_reg_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
// Ports: i_req      - request vector
//        i_ptr      - last winner; search starts at i_ptr+1 and wraps
//        o_winner_c - index of the first set request found
//        o_valid_c  - high when any request is set
module rr_pick
    import rr_shared_reg_arbiter_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned ID_W  = idw(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [ID_W-1:0]  o_winner_c,
    output logic             o_valid_c
);

    logic [ID_W-1:0] w_idx;

    // Walk from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        o_winner_c = '0;
        o_valid_c  = 1'b0;
        w_idx      = '0;
        for (int k = int'(N_REQ); k >= 1; k--) begin
            w_idx = ID_W'((int'(i_ptr) + k) % int'(N_REQ));
            if (i_req[w_idx]) begin
                o_winner_c = w_idx;
                o_valid_c  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_shared_reg_arbiter.sv
// Round-robin arbiter owning one shared WIDTH-bit register.
// A winner keeps ownership for up to MAX_BURST writes or until it drops req,
// then ownership returns to IDLE for at least one cycle before re-arbitration.
// Ports: clk - rising-edge clock
//        rst - synchronous active-high reset
//        bus - slave side: req/wdata in; gnt/ack/ack_id/q/busy out
module rr_shared_reg_arbiter
    import rr_shared_reg_arbiter_pkg::*;
#(
    parameter int unsigned      N_REQ     = 4,
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      MAX_BURST = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    rr_shared_reg_arbiter_if.slave  bus
);

    localparam int unsigned ID_W  = idw(N_REQ);
    localparam int unsigned CNT_W = idw(MAX_BURST + 1);

    state_t           r_state, w_state_nxt;
    logic [ID_W-1:0]  r_owner, w_owner_nxt;
    logic [ID_W-1:0]  r_ptr,   w_ptr_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic [N_REQ-1:0] r_gnt,   w_gnt_nxt;
    logic [WIDTH-1:0] r_q,     w_q_nxt;

    logic             w_ack;
    logic             w_last;
    logic [WIDTH-1:0] w_lane;
    logic [ID_W-1:0]  w_pick_idx;
    logic             w_pick_valid;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .i_req      (bus.req),
        .i_ptr      (r_ptr),
        .o_winner_c (w_pick_idx),
        .o_valid_c  (w_pick_valid)
    );

    // Owner's write-data lane.
    always_comb begin
        w_lane = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (r_owner == ID_W'(i)) begin
                w_lane = bus.wdata[i*int'(WIDTH) +: WIDTH];
            end
        end
    end

    // State register; reset takes priority over any pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= ID_W'(N_REQ - 1);
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_q     <= RESET_VAL;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_q     <= w_q_nxt;
        end
    end

    // Next-state and ack logic.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        w_q_nxt     = r_q;
        w_ack       = 1'b0;
        w_last      = (r_cnt == CNT_W'(MAX_BURST - 1));

        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = BUSY;
                    w_owner_nxt = w_pick_idx;
                    w_gnt_nxt   = N_REQ'(1) << w_pick_idx;
                    w_cnt_nxt   = '0;
                end
            end
            BUSY: begin
                w_ack = bus.req[r_owner];
                if (w_ack) begin
                    w_q_nxt   = w_lane;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
                // Release on a dropped request or after the final burst write.
                if (!w_ack || w_last) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = r_owner;
                    w_owner_nxt = '0;
                    w_cnt_nxt   = '0;
                end
            end
            default: ;
        endcase
    end

    assign bus.gnt    = r_gnt;
    assign bus.ack    = w_ack;
    assign bus.ack_id = r_owner;
    assign bus.q      = r_q;
    assign bus.busy   = (r_state == BUSY);

endmodule

// File: doc/rr_shared_reg_arbiter.md
Name: rr_shared_reg_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit register between N_REQ requesters. The register is a bank of synchronous-reset D flip-flops.
- A granted requester may write for up to MAX_BURST consecutive cycles. Ownership is then released and re-arbitrated, so no requester can starve the others.
- Sits between multiple producer blocks and a single shared state/config register in the sequential library.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, width of the shared register and of each write-data lane.
- MAX_BURST, 4, maximum consecutive writes per grant (>=1).
- RESET_VAL, 0, value loaded into q on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  N_REQ  per-requester request; bit i held high while requester i wants to write.
- wdata  input  N_REQ*WIDTH  lane i = wdata[i*WIDTH +: WIDTH].
- gnt  output  N_REQ  registered one-hot grant; all zero when idle.
- ack  output  1  high in a cycle where the owner's write is captured at the next edge.
- ack_id  output  clog2(N_REQ)  index of the current owner; 0 when idle.
- q  output  WIDTH  shared register contents.
- busy  output  1  high while state = BUSY.

Behaviour:
- Reset, sampled only on a rising clk edge with rst=1:
  - state=IDLE, gnt=0, q=RESET_VAL, burst count cnt=0, ptr=N_REQ-1 (requester 0 wins first).
  - Outputs reset: ack=0, ack_id=0, busy=0.
  - rst mid-burst aborts at that edge. No write happens on that edge, even if ack was high in that cycle.
- The FSM has two states, IDLE and BUSY.
- IDLE:
  - If any req bit is high, pick the first set bit searching ptr+1, ptr+2, … with modulo-N_REQ wrap.
  - At the edge: gnt <= onehot(winner), owner <= winner, cnt <= 0, state <= BUSY.
  - If no req bit is high, stay in IDLE.
  - Grant latency is 1 cycle from req sampled to gnt visible.
- BUSY:
  - ack = req[owner], combinational from registered state. ack_id = owner.
  - If req[owner]=1:
    - At the edge, q <= wdata lane owner and cnt <= cnt+1.
    - If cnt == MAX_BURST-1, release.
  - If req[owner]=0: release with no write and ack=0.
  - Release at the edge: state <= IDLE, gnt <= 0, ptr <= owner, cnt <= 0.
  - There is always at least one IDLE cycle between grants, including when the same requester re-wins.
- Requests from non-owners during BUSY are ignored and produce no ack. They are considered at the next IDLE.
- Fairness bound: a continuously requesting requester is granted within N_REQ-1 other grants. Worst-case wait is (N_REQ-1)*(MAX_BURST+1)+1 cycles.
- q changes only on an ack cycle edge or on reset; otherwise q holds.
- All lanes are ignored while idle.
- Invariants:
  - gnt has at most one bit set.
  - busy == (gnt != 0).
  - ack implies busy.
- Width rules:
  - cnt width is clog2(MAX_BURST+1).
  - ptr/owner width is clog2(N_REQ). When N_REQ is a power of two, the modulo wrap is natural overflow.

Decomposition:
- Shared package holds:
  - The state encoding constants IDLE=0 and BUSY=1.
  - A clog2 function for the ID/counter widths.
- The natural sub-module is rr_pick: a combinational round-robin priority picker.
  - Inputs: req vector and ptr.
  - Outputs: winner index and a valid flag.
  - It is reusable by other arbiters.
- The FSM, cnt and the q register stay in the top module.

Test Plan:
1. rst=1 for 2 edges, then 0, with req=0000 -> gnt=0000, q=00, busy=0, ack=0 for 5 cycles.
2. req=0001, wdata lane0=A5 held steady -> gnt=0001 one cycle after req. ack high for 4 cycles and q=A5 after the first ack edge. Release after 4 writes, one IDLE cycle, then re-grant to requester 0.
3. req=1111 held, lane i=10+i -> grants in order 0001, 0010, 0100, 1000, 0001 with an IDLE cycle between each. q goes 10, 11, 12, 13.
4. Requester 2 granted, drops req after 2 writes of 3C -> q=3C, release on the drop cycle with no third write, ptr=2. The next arbitration with req=1111 picks requester 3.
5. Requester 1 in mid-burst with q=55, assert rst in the cycle where ack=1 and lane1=AA -> at that edge q=RESET_VAL (00, not AA), gnt=0000, busy=0. The next grant goes to requester 0 first.
6. Owner=0 in BUSY while req[3] toggles -> ack_id stays 0, ack tracks req[0] only, and q never takes lane 3 until requester 3 is granted.
